// File: rtl/trng_pool.sv
// rtl/trng_pool.sv - pooled entropy collector with repetition-count health test and FWFT output FIFO
//
// trng_pool: N_SRC synchronised entropy lanes are XORed into one raw bit per
// cycle. Raw bits are optionally von Neumann debiased, then packed MSB-first
// into WIDTH-bit words. Words are buffered in a DEPTH-entry first-word-fall-through
// FIFO. A repetition-count test latches health_fail and flushes all state.
// Optional feature macro: TRNG_VN_DEBIAS_EN (debias FSM in the datapath).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   enable       high = collect entropy; low = freeze collection (FIFO still pops)
//   entropy_in   [N_SRC] asynchronous entropy lanes
//   rand_data    [WIDTH] head-of-FIFO word, zero while rand_valid is low
//   rand_valid   FIFO not empty and no health failure
//   rand_ready   consumer accept; pop on rand_valid & rand_ready
//   fill_level   FIFO occupancy
//   health_fail  sticky repetition-count failure, cleared only by reset
//
// trng_pool_fifo: FWFT word FIFO with flush.
//   s_tdata/s_tvalid/s_tready  write side (push when full allowed if m_tready)
//   m_tdata/m_tvalid/m_tready  read side, head word shown combinationally
//   count                      occupancy

module trng_pool_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [WIDTH-1:0]           m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign s_tready = (count != FULL_CNT) || m_tready;
    assign do_pop   = m_tvalid && m_tready;
    assign do_push  = s_tvalid && s_tready;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module trng_pool #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int N_SRC      = 2,
    parameter int RCT_CUTOFF = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_SRC-1:0]           entropy_in,
    output logic [WIDTH-1:0]           rand_data,
    output logic                       rand_valid,
    input  logic                       rand_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       health_fail
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [7:0]    RCT_LIMIT = 8'(RCT_CUTOFF);

    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;
    logic [1:0]       sync_vld;
    logic             raw_bit;
    logic             raw_ok;
    logic             take;
    logic             stall;
    logic             prev_raw;
    logic [7:0]       run_cnt;
    logic [7:0]       run_next;
    logic             rct_trip;
    logic             emit;
    logic             emit_bit;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] word_q;
    logic             word_pend;
    logic [BW-1:0]    bit_cnt;
    logic             fifo_s_tready;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_m_tvalid;

    // sync_vld marks when sync2 holds real samples, so the cleared flops are
    // never mistaken for entropy after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sync_vld <= 2'b00;
        end else begin
            sync1    <= entropy_in;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign raw_bit = ^sync2;
    assign raw_ok  = enable && sync_vld[1] && !health_fail;
    // A completed word waits in word_q; collection freezes only if it cannot leave.
    assign stall   = word_pend && !fifo_s_tready;
    assign take    = raw_ok && !stall;

    // Repetition count sees every raw bit while enabled, stalled or not.
    assign run_next = (raw_bit != prev_raw) ? 8'd1 : run_cnt + 8'd1;
    assign rct_trip = raw_ok && (run_next == RCT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_raw    <= 1'b0;
            run_cnt     <= 8'd0;
            health_fail <= 1'b0;
        end else if (raw_ok) begin
            prev_raw <= raw_bit;
            run_cnt  <= run_next;
            if (rct_trip) begin
                health_fail <= 1'b1;
            end
        end
    end

`ifdef TRNG_VN_DEBIAS_EN
    typedef enum logic {DB_FIRST, DB_SECOND} db_state_t;
    db_state_t db_state;
    logic      db_latch;

    always_ff @(posedge clk) begin
        if (reset || rct_trip) begin
            db_state <= DB_FIRST;
            db_latch <= 1'b0;
        end else if (take) begin
            if (db_state == DB_FIRST) begin
                db_latch <= raw_bit;
                db_state <= DB_SECOND;
            end else begin
                db_state <= DB_FIRST;
            end
        end
    end

    assign emit     = take && (db_state == DB_SECOND) && (raw_bit != db_latch);
    assign emit_bit = db_latch;
`else
    assign emit     = take;
    assign emit_bit = raw_bit;
`endif

    assign shift_next = {shift_q[WIDTH-2:0], emit_bit};

    always_ff @(posedge clk) begin
        if (reset || rct_trip) begin
            shift_q   <= '0;
            word_q    <= '0;
            word_pend <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            if (word_pend && fifo_s_tready) begin
                word_pend <= 1'b0;
            end
            if (emit) begin
                if (bit_cnt == LAST_BIT) begin
                    word_q    <= shift_next;
                    word_pend <= 1'b1;
                    bit_cnt   <= '0;
                end else begin
                    shift_q <= shift_next;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    trng_pool_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (rct_trip),
        .s_tdata  (word_q),
        .s_tvalid (word_pend),
        .s_tready (fifo_s_tready),
        .m_tdata  (fifo_head),
        .m_tvalid (fifo_m_tvalid),
        .m_tready (rand_ready && !health_fail),
        .count    (fill_level)
    );

    assign rand_valid = fifo_m_tvalid && !health_fail;
    assign rand_data  = rand_valid ? fifo_head : '0;
endmodule
